// File: rtl/rgb2gray_stream.sv
// Streaming RGB to grayscale, 4-stage pipeline, four Q8 luma sets.
// Optional RGB2GRAY_ROUND_EN: round half up instead of truncating.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     input handshake
//   in_red/green/blue     DW-bit channels
//   in_mode               coefficient set (0..3)
//   in_last               end-of-line marker
//   out_valid/out_ready   output handshake
//   out_gray, out_last    result and aligned marker
//   cnt_clr, pix_count    delivered-pixel counter and sync clear
module rgb2gray_stream #(
  parameter int DW      = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      in_red,
  input  logic [DW-1:0]      in_green,
  input  logic [DW-1:0]      in_blue,
  input  logic [1:0]         in_mode,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_gray,
  output logic               out_last,
  input  logic               cnt_clr,
  output logic [COUNT_W-1:0] pix_count
);

  localparam int PW = DW + 8;
  localparam int SW = DW + 10;
  localparam logic [SW-1:0] MAXV = SW'((1 << DW) - 1);

  typedef struct packed {
    logic          v;
    logic [DW-1:0] r;
    logic [DW-1:0] g;
    logic [DW-1:0] b;
    logic [1:0]    mode;
    logic          last;
  } s1_t;

  typedef struct packed {
    logic          v;
    logic [PW-1:0] pr;
    logic [PW-1:0] pg;
    logic [PW-1:0] pb;
    logic          last;
  } s2_t;

  typedef struct packed {
    logic          v;
    logic [SW-1:0] sum;
    logic          last;
  } s3_t;

  s1_t s1;
  s2_t s2;
  s3_t s3;

  logic          adv;
  logic [7:0]    kr;
  logic [7:0]    kg;
  logic [7:0]    kb;
  logic [PW-1:0] pr_n;
  logic [PW-1:0] pg_n;
  logic [PW-1:0] pb_n;
  logic [SW-1:0] sum_n;
  logic [SW-1:0] biased;
  logic [SW-1:0] shifted;
  logic [DW-1:0] gray_n;

  // Whole pipeline moves in lockstep; bubbles are kept.
  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  always_comb begin
    kr = 8'd72;
    kg = 8'd144;
    kb = 8'd24;
    unique case (s1.mode)
      2'd0: begin kr = 8'd72; kg = 8'd144; kb = 8'd24; end
      2'd1: begin kr = 8'd77; kg = 8'd150; kb = 8'd29; end
      2'd2: begin kr = 8'd54; kg = 8'd183; kb = 8'd19; end
      2'd3: begin kr = 8'd85; kg = 8'd85;  kb = 8'd85; end
    endcase
  end

  assign pr_n = PW'(s1.r) * PW'(kr);
  assign pg_n = PW'(s1.g) * PW'(kg);
  assign pb_n = PW'(s1.b) * PW'(kb);

  assign sum_n = SW'(s2.pr) + SW'(s2.pg) + SW'(s2.pb);

`ifdef RGB2GRAY_ROUND_EN
  assign biased = s3.sum + SW'(128);
`else
  assign biased = s3.sum;
`endif

  assign shifted = biased >> 8;
  assign gray_n  = (shifted > MAXV) ? {DW{1'b1}} :
                   shifted[DW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      out_valid <= 1'b0;
      out_gray  <= '0;
      out_last  <= 1'b0;
    end else if (adv) begin
      s1.v      <= in_valid;
      s1.r      <= in_red;
      s1.g      <= in_green;
      s1.b      <= in_blue;
      s1.mode   <= in_mode;
      s1.last   <= in_last;
      s2.v      <= s1.v;
      s2.pr     <= pr_n;
      s2.pg     <= pg_n;
      s2.pb     <= pb_n;
      s2.last   <= s1.last;
      s3.v      <= s2.v;
      s3.sum    <= sum_n;
      s3.last   <= s2.last;
      out_valid <= s3.v;
      out_gray  <= gray_n;
      out_last  <= s3.last;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_count <= '0;
    end else if (cnt_clr) begin
      pix_count <= '0;
    end else if (out_valid && out_ready) begin
      pix_count <= pix_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Directed bench for rgb2gray_stream (COUNT_W=4).
// Expected values are hand-computed per build.
module tb_rgb2gray_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_red = '0;
  logic [7:0] in_green = '0;
  logic [7:0] in_blue = '0;
  logic [1:0] in_mode = '0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] out_gray;
  logic       out_last;
  logic       cnt_clr = 1'b0;
  logic [3:0] pix_count;

  rgb2gray_stream #(.DW(8), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_red(in_red), .in_green(in_green),
    .in_blue(in_blue), .in_mode(in_mode),
    .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_gray(out_gray), .out_last(out_last),
    .cnt_clr(cnt_clr), .pix_count(pix_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    logic [1:0] mode;
    logic [7:0] exp;
  } vec_t;

  vec_t tv[10];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm,
                     input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d",
               nm, act, req);
    end
  endtask

  task automatic put(input int i,
                     input logic v,
                     input logic l);
    in_red   = tv[i].r;
    in_green = tv[i].g;
    in_blue  = tv[i].b;
    in_mode  = tv[i].mode;
    in_last  = l;
    in_valid = v;
  endtask

  initial begin
    int lat;
    int got;
    int nout;
    int idx;
    int cnt;
    int ntx;
    int sent;
    int stall_cnt;
    int prev_stall;
    int prev_gray;
    int sidx[6];

`ifdef RGB2GRAY_ROUND_EN
    tv[1] = '{8'd255, 8'd0,   8'd0,   2'd0, 8'd77};
    tv[2] = '{8'd200, 8'd200, 8'd200, 2'd0, 8'd188};
    tv[7] = '{8'd100, 8'd50,  8'd25,  2'd0, 8'd59};
    tv[9] = '{8'd1,   8'd2,   8'd3,   2'd3, 8'd2};
`else
    tv[1] = '{8'd255, 8'd0,   8'd0,   2'd0, 8'd76};
    tv[2] = '{8'd200, 8'd200, 8'd200, 2'd0, 8'd187};
    tv[7] = '{8'd100, 8'd50,  8'd25,  2'd0, 8'd58};
    tv[9] = '{8'd1,   8'd2,   8'd3,   2'd3, 8'd1};
`endif
    tv[1].mode = 2'd1;
    tv[0] = '{8'd255, 8'd255, 8'd255, 2'd1, 8'd255};
    tv[3] = '{8'd0,   8'd255, 8'd0,   2'd2, 8'd182};
    tv[4] = '{8'd255, 8'd255, 8'd255, 2'd3, 8'd254};
    tv[5] = '{8'd0,   8'd0,   8'd0,   2'd0, 8'd0};
    tv[6] = '{8'd255, 8'd255, 8'd255, 2'd2, 8'd255};
    tv[8] = '{8'd10,  8'd20,  8'd30,  2'd1, 8'd18};
    sidx  = '{2, 1, 3, 4, 7, 8};

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_gray", out_gray, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pix_count", pix_count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // single pixels: value and latency
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      put(i, 1'b1, 1'b0);
      #1 chk("vec_in_ready", in_ready, 1);
      lat = 0;
      got = 0;
      while (lat < 20 && got == 0) begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
        if (out_valid) got = 1;
      end
      chk($sformatf("vec%0d_latency", i), lat, 4);
      chk($sformatf("vec%0d_gray", i),
          out_gray, tv[i].exp);
      chk($sformatf("vec%0d_last", i), out_last, 0);
      @(negedge clk);
      chk("vec_drain", out_valid, 0);
    end

    // reset mid-stream
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      put(0, 1'b1, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pix_count", pix_count, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    got = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    chk("midrst_stray_outputs", got, 0);

    // back-to-back stream, per-pixel modes
    nout = 0;
    idx = -1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (out_valid) begin
        if (idx < 0) idx = c;
        chk("stream_consecutive", c, idx + nout);
        if (nout < 6) begin
          chk($sformatf("stream%0d_gray", nout),
              out_gray, tv[sidx[nout]].exp);
          chk($sformatf("stream%0d_last", nout),
              out_last, (nout == 5) ? 1 : 0);
        end
        nout++;
      end
      if (c < 6) put(sidx[c], 1'b1, c == 5);
      else in_valid = 1'b0;
    end
    chk("stream_first_cycle", idx, 4);
    chk("stream_count", nout, 6);
    in_last = 1'b0;

    // backpressure
    nout = 0;
    idx = 0;
    stall_cnt = 0;
    prev_stall = 0;
    prev_gray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      out_ready = !(nout >= 1 && stall_cnt < 8);
      if (!out_ready) stall_cnt++;
      if (idx < 6) put(idx, 1'b1, idx == 5);
      else in_valid = 1'b0;
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", in_ready, 0);
        if (prev_stall != 0)
          chk("bp_gray_stable", out_gray, prev_gray);
        prev_stall = 1;
        prev_gray = out_gray;
      end else begin
        prev_stall = 0;
      end
      if (in_valid && in_ready) idx++;
      if (out_valid && out_ready) begin
        if (nout < 6) begin
          chk($sformatf("bp%0d_gray", nout),
              out_gray, tv[nout].exp);
          chk($sformatf("bp%0d_last", nout),
              out_last, (nout == 5) ? 1 : 0);
        end
        nout++;
      end
    end
    chk("bp_stall_cycles", stall_cnt, 8);
    chk("bp_accepted", idx, 6);
    chk("bp_delivered", nout, 6);
    in_valid = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;

    // counter wrap
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("cnt_clear_idle", pix_count, 0);
    cnt = 0;
    ntx = 0;
    sent = 0;
    for (int c = 0; c < 60 && ntx < 17; c++) begin
      if (c > 0) @(negedge clk);
      chk("cnt_value", pix_count, cnt);
      if (out_valid) begin
        cnt = (cnt + 1) % 16;
        ntx++;
      end
      if (sent < 17) begin
        put(5, 1'b1, 1'b0);
        sent++;
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("cnt_transfers", ntx, 17);
    chk("cnt_wrapped", pix_count, 1);

    // clear coinciding with a transfer
    @(negedge clk);
    put(0, 1'b1, 1'b0);
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) got = 1;
    end
    chk("clr_out_seen", got, 1);
    chk("clr_pre_count", pix_count, 1);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_priority", pix_count, 0);
    chk("clr_transfer_done", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
